mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares a single memory port between `NUM_REQ` bus masters, such as matrix-multiplication engines and the CPU load/store path. Each requester and the memory side use the same `mem_operation` / `mem_opdone` handshake (01 read, 11 write, 00 none). The arbiter grants one access at a time, forwards the captured address and data to memory, and routes the completion and read data back. A watchdog converts a hung memory access into a flagged completion, so requesters never deadlock.

## Interface
- `NUM_REQ`, 2: number of requesters (1–8).
- `DATA_W`, 32: data width (set to `` `TYPE_BW`` at instantiation).
- `ADDR_W`, 32: address width.
- `TIMEOUT_CYCLES`, 1024: cycles allowed for a memory access. 0 disables the watchdog.

Ports:
- `clk`  in  1  sole clock. One clock; all logic on `posedge clk`.
- `reset`  in  1  synchronous, active-high reset.
- `req_op_i`  in  2*NUM_REQ  per-requester operation; slice r is `[2r+1:2r]`.
- `req_addr_i`  in  ADDR_W*NUM_REQ  per-requester address.
- `req_wdata_i`  in  DATA_W*NUM_REQ  per-requester write data.
- `req_opdone_o`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_rdata_o`  out  DATA_W  read data, shared by all requesters and valid when that requester's opdone is high.
- `grant_o`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `mem_operation_o`  out  2  operation to memory.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_rdata_i`  in  DATA_W  memory read data, valid with `mem_opdone_i`.
- `mem_opdone_i`  in  1  memory completion pulse.
- `busy_o`  out  1  high in BUSY and RESP.
- `timeout_o`  out  1  one-cycle pulse when the watchdog aborts an access.

## Operation
- **Valid request:** `req_op_i` slice equal to 01 or 11. Code 10 is ignored (treated as 00).
- **States:** IDLE, BUSY, RESP.
- **IDLE:**
  - If any valid request exists, pick the winner by round-robin, searching from `last_grant+1` upward with wrap-around.
  - Latch the winner's op, address and write data into `mem_operation_o`, `mem_addr_o` and `mem_wdata_o`.
  - Set `grant_o`, update `last_grant`, clear the watchdog, then go to BUSY.
  - Otherwise stay in IDLE with all memory outputs at 00/0.
- **BUSY:**
  - Hold the memory outputs stable.
  - On `mem_opdone_i`:
    - For reads, capture `mem_rdata_i` into `req_rdata_o`.
    - Pulse the winner's `req_opdone_o` next cycle, drive `mem_operation_o` to 00, and go to RESP.
  - If the watchdog reaches `TIMEOUT_CYCLES` first:
    - Drive `req_rdata_o` to 0 and `mem_operation_o` to 00.
    - Pulse the winner's `req_opdone_o` and `timeout_o`, then go to RESP.
- **RESP:**
  - Hold `req_opdone_o` and `timeout_o` high for this single cycle, keep `grant_o`, then return to IDLE.
  - This cycle lets the requester update its op/address before the next sample.
- **Request capture:** changes to a requester's inputs after grant are ignored until its opdone. A requester dropping its op mid-access still receives opdone.
- **Write completion:** `req_rdata_o` keeps its previous value.
- **`last_grant` at reset:** `NUM_REQ-1`, so requester 0 wins the first tie.
- **Reset:** asserting `reset` in any state, including mid-access, forces IDLE and all reset values on the next edge. No opdone is issued for the aborted access.
- **Reset values:**
  - `grant_o`, `req_opdone_o`, `req_rdata_o`, `mem_operation_o`, `mem_addr_o`, `mem_wdata_o`, `busy_o`, `timeout_o` = 0.
  - Watchdog = 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Access sequence** (request valid in IDLE cycle 0):
  - `mem_operation_o` and `grant_o` valid in cycle 1.
  - `mem_opdone_i` is legal from cycle 1 onwards; if it arrives in cycle M, `req_opdone_o` and `req_rdata_o` are valid in cycle M+1 (RESP).
  - IDLE resumes in cycle M+2.
- **Minimum latency:** 2 cycles from request to opdone. **Minimum period:** 3 cycles per access.
- **Memory idle gap:** `mem_operation_o` is 00 for at least 2 cycles between consecutive accesses.
- **Watchdog:** counts BUSY cycles starting at 1 in cycle 1. Abort happens at the edge where the count equals `TIMEOUT_CYCLES` without `mem_opdone_i`. A `mem_opdone_i` in that same cycle wins over the timeout.
- **Spurious completions:** `mem_opdone_i` in IDLE or RESP is ignored.

## Test plan
- **Single read:** requester 0 reads address 0x10, memory returns 0xDEAD_BEEF with 2-cycle latency -> `grant_o`=01 in cycle 1, `req_opdone_o[0]` in cycle 4 with `req_rdata_o`=0xDEAD_BEEF.
- **Single write:** requester 1 writes 0x55 to address 0x20 -> `mem_operation_o`=11, `mem_addr_o`=0x20, `mem_wdata_o`=0x55 held until `mem_opdone_i`; `req_opdone_o[1]` one cycle later.
- **Contention:** both requesters hold continuous reads from reset -> grants alternate 0,1,0,1, with no requester served twice in a row while the other waits.
- **Burst fetch:** requester 0 steps addresses 0..3 on each opdone while requester 1 requests once -> four correct reads for requester 0 with requester 1 interleaved after the first; every address is issued exactly once.
- **Timeout:** `TIMEOUT_CYCLES`=8, memory never responds -> `timeout_o` and `req_opdone_o` pulse in cycle 9 with `req_rdata_o`=0; the next request proceeds normally.
- **Reset mid-access:** assert `reset` in BUSY -> next cycle all outputs are 0, state IDLE, no opdone; after release, requester 0 wins the first tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin sharing of one memory port among NUM_REQ
// masters, with a watchdog that turns a hung access into a flagged completion.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_REQ-1:0]      req_op_i,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_opdone_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [1:0]                mem_operation_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  input  logic                      mem_opdone_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               WD_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W:0]   NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    last_grant, last_nx;
  logic [WD_W-1:0]     wdog, wdog_nx;
  logic [NUM_REQ-1:0]  valid;
  logic [IDX_W-1:0]    win;
  logic [IDX_W:0]      cand;
  logic                found;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [NUM_REQ-1:0]  grant_nx, opdone_nx;
  logic [DATA_W-1:0]   rdata_nx, wdata_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [1:0]          op_nx;
  logic                busy_nx, timeout_nx;

  // Codes 01 and 11 are the only valid ones; both have bit 0 set.
  always_comb begin
    valid = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      valid[r] = req_op_i[2*r];
    end
  end

  // Search starts one past the previous owner and wraps around.
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IDX_W + 1)'(k);
      if (cand >= NUM_REQ_V) begin
        cand = cand - NUM_REQ_V;
      end
      if (!found && valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_op     = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    win_onehot = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win == IDX_W'(r)) begin
        sel_op        = req_op_i[2*r +: 2];
        sel_addr      = req_addr_i[ADDR_W*r +: ADDR_W];
        sel_wdata     = req_wdata_i[DATA_W*r +: DATA_W];
        win_onehot[r] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last_grant;
    wdog_nx    = wdog;
    grant_nx   = grant_o;
    op_nx      = mem_operation_o;
    addr_nx    = mem_addr_o;
    wdata_nx   = mem_wdata_o;
    rdata_nx   = req_rdata_o;
    opdone_nx  = '0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = '0;
        op_nx    = 2'b00;
        addr_nx  = '0;
        wdata_nx = '0;
        if (found) begin
          state_nx = BUSY;
          grant_nx = win_onehot;
          op_nx    = sel_op;
          addr_nx  = sel_addr;
          wdata_nx = sel_wdata;
          last_nx  = win;
          wdog_nx  = WD_W'(1);
        end
      end
      BUSY: begin
        // A completion arriving on the limit cycle still wins over the abort.
        if (mem_opdone_i) begin
          if (mem_operation_o != 2'b11) begin
            rdata_nx = mem_rdata_i;
          end
          opdone_nx = grant_o;
          op_nx     = 2'b00;
          state_nx  = RESP;
        end else if (WD_EN && (wdog == WD_LIMIT)) begin
          rdata_nx   = '0;
          op_nx      = 2'b00;
          opdone_nx  = grant_o;
          timeout_nx = 1'b1;
          state_nx   = RESP;
        end else if (WD_EN) begin
          wdog_nx = wdog + WD_W'(1);
        end
      end
      RESP: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        op_nx    = 2'b00;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= LAST_RST;
      wdog            <= '0;
      grant_o         <= '0;
      req_opdone_o    <= '0;
      req_rdata_o     <= '0;
      mem_operation_o <= 2'b00;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      busy_o          <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      state           <= state_nx;
      last_grant      <= last_nx;
      wdog            <= wdog_nx;
      grant_o         <= grant_nx;
      req_opdone_o    <= opdone_nx;
      req_rdata_o     <= rdata_nx;
      mem_operation_o <= op_nx;
      mem_addr_o      <= addr_nx;
      mem_wdata_o     <= wdata_nx;
      busy_o          <= busy_nx;
      timeout_o       <= timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench for mem_port_arbiter with a small
// latency-programmable memory model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_opdone;
  logic [31:0] req_rdata;
  logic [1:0]  grant;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_opdone = 1'b0;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  int          lat  = 2;
  bit          hang = 1'b0;
  int          cnt  = 0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr  = 32'h0;
  logic [31:0] wr_data  = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ(2), .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_opdone_o(req_opdone), .req_rdata_o(req_rdata), .grant_o(grant),
    .mem_operation_o(mem_op), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_opdone_i(mem_opdone),
    .busy_o(busy), .timeout_o(timeout)
  );

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + a * 32'h0101;
  endfunction

  // Memory answers `lat` cycles after it first sees an operation.
  always @(posedge clk) begin
    mem_opdone <= 1'b0;
    if (mem_op != 2'b00 && !mem_opdone && !hang) begin
      if (cnt >= lat - 1) begin
        mem_opdone <= 1'b1;
        cnt        <= 0;
        if (mem_op == 2'b11) begin
          wr_valid <= 1'b1;
          wr_addr  <= mem_addr;
          wr_data  <= mem_wdata;
        end else begin
          mem_rdata <= mem_init(mem_addr);
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   grant, 0);
    check({tag, "_opdone"},  req_opdone, 0);
    check({tag, "_rdata"},   req_rdata, 0);
    check({tag, "_memop"},   mem_op, 0);
    check({tag, "_addr"},    mem_addr, 0);
    check({tag, "_wdata"},   mem_wdata, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int          got_n;
    int          n;
    int          b0;
    int          issues;
    logic [1:0]  prev_op;
    logic [4:0]  ord;
    logic [31:0] a0;
    logic [1:0]  exp_g;

    reset = 1'b1; req_op = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Single read by requester 0
    req_op = 4'b0001; req_addr[31:0] = 32'h10;
    tick();
    check("rd_grant", grant, 2'b01);
    check("rd_memop", mem_op, 2'b01);
    check("rd_addr",  mem_addr, 32'h10);
    check("rd_busy",  busy, 1);
    req_op = 4'b0000;
    tick(); tick();
    check("rd_early", req_opdone, 2'b00);
    tick();
    check("rd_opdone", req_opdone, 2'b01);
    check("rd_rdata",  req_rdata, 32'hDEAD_BEEF);
    check("rd_grant_resp", grant, 2'b01);
    tick();
    check("rd_idle_grant",  grant, 0);
    check("rd_idle_busy",   busy, 0);
    check("rd_idle_opdone", req_opdone, 0);

    // Single write by requester 1, inputs change after grant
    req_op = 4'b1100; req_addr[63:32] = 32'h20; req_wdata[63:32] = 32'h55;
    tick();
    check("wr_memop", mem_op, 2'b11);
    check("wr_addr",  mem_addr, 32'h20);
    check("wr_wdata", mem_wdata, 32'h55);
    check("wr_grant", grant, 2'b10);
    req_addr[63:32] = 32'h99; req_wdata[63:32] = 32'hAA; req_op = 4'b0000;
    tick();
    check("wr_hold_addr",  mem_addr, 32'h20);
    check("wr_hold_wdata", mem_wdata, 32'h55);
    tick(); tick();
    check("wr_opdone", req_opdone, 2'b10);
    check("wr_rdata_kept", req_rdata, 32'hDEAD_BEEF);
    check("wr_mem_addr", wr_addr, 32'h20);
    check("wr_mem_data", wr_data, 32'h55);
    tick();

    // Contention: both read continuously
    req_op = 4'b0101; req_addr = {32'h2, 32'h1};
    got_n = 0;
    for (int c = 0; c < 40 && got_n < 4; c++) begin
      tick();
      if (req_opdone != 2'b00) begin
        exp_g = (got_n % 2 == 0) ? 2'b01 : 2'b10;
        check("cont_owner", req_opdone, exp_g);
        check("cont_rdata", req_rdata, mem_init(exp_g == 2'b01 ? 32'h1 : 32'h2));
        got_n++;
        if (got_n == 4) req_op = 4'b0000;
      end
    end
    check("cont_count", got_n, 4);
    tick(); tick();

    // Burst fetch: requester 0 steps 0..3, requester 1 asks once for 5
    a0 = 32'h0;
    req_op = 4'b0101; req_addr = {32'h5, a0};
    n = 0; b0 = 0; issues = 0; ord = '0; prev_op = 2'b00;
    for (int c = 0; c < 80 && n < 5; c++) begin
      tick();
      if (mem_op != 2'b00 && prev_op == 2'b00) issues++;
      prev_op = mem_op;
      if (req_opdone[0]) begin
        check("bf_rd0", req_rdata, mem_init(a0));
        ord[n] = 1'b0; n++; b0++;
        if (b0 == 4) req_op[1:0] = 2'b00;
        else begin
          a0 = a0 + 1;
          req_addr[31:0] = a0;
        end
      end
      if (req_opdone[1]) begin
        check("bf_rd1", req_rdata, mem_init(32'h5));
        ord[n] = 1'b1; n++;
        req_op[3:2] = 2'b00;
      end
    end
    check("bf_count",  n, 5);
    check("bf_order",  ord, 5'b00010);
    check("bf_issues", issues, 5);
    tick(); tick();

    // Completion on the watchdog limit cycle wins over the abort
    lat = 7;
    req_op = 4'b0001; req_addr[31:0] = 32'h3;
    tick();
    req_op = 4'b0000;
    repeat (7) tick();
    check("edge_memdone", mem_opdone, 1);
    tick();
    check("edge_opdone",  req_opdone, 2'b01);
    check("edge_timeout", timeout, 0);
    check("edge_rdata",   req_rdata, mem_init(32'h3));
    tick();
    lat = 2;

    // Watchdog abort with a silent memory
    hang = 1'b1;
    req_op = 4'b0001; req_addr[31:0] = 32'h10;
    tick();
    req_op = 4'b0000;
    repeat (7) tick();
    check("to_c8_opdone",  req_opdone, 0);
    check("to_c8_timeout", timeout, 0);
    check("to_c8_busy",    busy, 1);
    tick();
    check("to_timeout", timeout, 1);
    check("to_opdone",  req_opdone, 2'b01);
    check("to_rdata",   req_rdata, 0);
    check("to_memop",   mem_op, 0);
    tick();
    check("to_after_timeout", timeout, 0);
    check("to_after_grant",   grant, 0);
    hang = 1'b0;
    req_op = 4'b0100; req_addr[63:32] = 32'h10;
    tick();
    check("to_next_grant", grant, 2'b10);
    req_op = 4'b0000;
    tick(); tick(); tick();
    check("to_next_opdone", req_opdone, 2'b10);
    check("to_next_rdata",  req_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset in the middle of an access by requester 0
    hang = 1'b1;
    req_op = 4'b0001; req_addr[31:0] = 32'h7;
    tick();
    check("mr_grant", grant, 2'b01);
    req_op = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("mr");
    reset = 1'b0; hang = 1'b0;
    req_op = 4'b0101; req_addr = {32'h2, 32'h1};
    tick();
    check("mr_tie_grant", grant, 2'b01);
    req_op = 4'b0000;
    got_n = 0;
    for (int c = 0; c < 10 && got_n == 0; c++) begin
      tick();
      if (req_opdone != 2'b00) begin
        got_n = 1;
        check("mr_done_owner", req_opdone, 2'b01);
        check("mr_done_rdata", req_rdata, mem_init(32'h1));
      end
    end
    check("mr_done_seen", got_n, 1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
